// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester arbiter for a shared data_bus with a fixed-length access window
// Round-robin arbitration is compiled in by BUS_ARBITER_RR_EN; fixed priority (m0 first) otherwise.
module bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [1:0]        m0_len,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_exc,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [1:0]        m1_len,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_exc,
  output logic              bus_rw,
  output logic [1:0]        bus_len,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_write,
  input  logic [DATA_W-1:0] bus_read,
  input  logic              bus_exception
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              ready_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              bus_rw_q, bus_rw_d;
  logic [1:0]        bus_len_q, bus_len_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_write_q, bus_write_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              exc_q, exc_d;
  logic              winner;

`ifdef BUS_ARBITER_RR_EN
  logic last_q, last_d;

  // On contention the requester that did not own the bus last time wins.
  always_comb begin
    if (m0_req && m1_req) begin
      winner = ~last_q;
    end else begin
      winner = m1_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    winner = ~m0_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    bus_rw_d    = bus_rw_q;
    bus_len_d   = bus_len_q;
    bus_addr_d  = bus_addr_q;
    bus_write_d = bus_write_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    exc_d       = exc_q;
`ifdef BUS_ARBITER_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        // ready_q holds off arbitration for the first edge after reset release.
        if (ready_q && (m0_req || m1_req)) begin
          state_d = S_GRANT;
          owner_d = winner;
`ifdef BUS_ARBITER_RR_EN
          last_d  = winner;
`endif
        end
      end
      S_GRANT: begin
        state_d = S_ACCESS;
        cnt_d   = 4'd0;
        if (owner_q) begin
          bus_rw_d    = m1_rw;
          bus_len_d   = m1_len;
          bus_addr_d  = m1_addr;
          bus_write_d = m1_wdata;
        end else begin
          bus_rw_d    = m0_rw;
          bus_len_d   = m0_len;
          bus_addr_d  = m0_addr;
          bus_write_d = m0_wdata;
        end
      end
      S_ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d     = S_DONE;
          cnt_d       = 4'd0;
          bus_rw_d    = 1'b0;
          bus_len_d   = 2'd0;
          bus_addr_d  = '0;
          bus_write_d = '0;
          exc_d       = bus_exception;
          if (owner_q) begin
            m1_rdata_d = bus_read;
          end else begin
            m0_rdata_d = bus_read;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        exc_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      ready_q     <= 1'b0;
      cnt_q       <= 4'd0;
      bus_rw_q    <= 1'b0;
      bus_len_q   <= 2'd0;
      bus_addr_q  <= '0;
      bus_write_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ready_q     <= 1'b1;
      cnt_q       <= cnt_d;
      bus_rw_q    <= bus_rw_d;
      bus_len_q   <= bus_len_d;
      bus_addr_q  <= bus_addr_d;
      bus_write_q <= bus_write_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      exc_q       <= exc_d;
    end
  end

  // Grant/done decode purely from state so reset clears them without a clock edge.
  always_comb begin
    m0_gnt    = (state_q != S_IDLE) && !owner_q;
    m1_gnt    = (state_q != S_IDLE) && owner_q;
    m0_done   = (state_q == S_DONE) && !owner_q;
    m1_done   = (state_q == S_DONE) && owner_q;
    m0_exc    = m0_done && exc_q;
    m1_exc    = m1_done && exc_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
    bus_rw    = bus_rw_q;
    bus_len   = bus_len_q;
    bus_addr  = bus_addr_q;
    bus_write = bus_write_q;
  end

endmodule
